// File: rtl/adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer
//
// Scan controller for the sensor front-end. On a start command it powers the
// PLL, walks the analog mux through a latched channel mask in ascending order,
// triggers one conversion per channel and reports each result with its channel
// tag. A completion pulse marks the end of every scan. In continuous mode the
// scan repeats after a programmable idle period.
//
// Ports
//   PCLK, PRESETn        clock, synchronous active-low reset
//   cfg_enable           enable; low aborts any activity
//   cfg_single           1 = one-shot scan, 0 = continuous
//   cfg_start            one-cycle start request
//   cfg_ch_mask          channels to convert (latched at scan start)
//   cfg_period           idle cycles between continuous scans
//   cfg_err_clr          clears err_timeout
//   pll_en / pll_locked  PLL power request / lock indication
//   amux_sel             analog mux channel select
//   adc_trigger          one-cycle conversion start
//   adc_done / adc_data  conversion complete strobe / result
//   res_valid/ch/data    registered result strobe, channel tag and value
//   busy                 sequencer not idle
//   scan_done_irq        one-cycle end-of-scan pulse
//   err_timeout          sticky PLL-lock or conversion timeout flag
// -----------------------------------------------------------------------------
module adc_scan_sequencer #(
    parameter int NUM_CH         = 8,
    parameter int CH_W           = 3,
    parameter int RES_W          = 12,
    parameter int TMR_W          = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cfg_enable,
    input  logic              cfg_single,
    input  logic              cfg_start,
    input  logic [NUM_CH-1:0] cfg_ch_mask,
    input  logic [TMR_W-1:0]  cfg_period,
    input  logic              cfg_err_clr,
    output logic              pll_en,
    input  logic              pll_locked,
    output logic [CH_W-1:0]   amux_sel,
    output logic              adc_trigger,
    input  logic              adc_done,
    input  logic [RES_W-1:0]  adc_data,
    output logic              res_valid,
    output logic [CH_W-1:0]   res_ch,
    output logic [RES_W-1:0]  res_data,
    output logic              busy,
    output logic              scan_done_irq,
    output logic              err_timeout
);

    // One counter serves both the settle wait and the timeout waits.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] TMR_ONE      = {{(TMR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PLL_WAIT = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_TRIG     = 3'd3,
        ST_CONVERT  = 3'd4,
        ST_PERIOD   = 3'd5
    } state_t;

    state_t              state_r;
    logic [NUM_CH-1:0]   mask_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [TMR_W-1:0]    tmr_r;
    logic                pll_en_r;
    logic [CH_W-1:0]     amux_sel_r;
    logic                adc_trigger_r;
    logic                res_valid_r;
    logic [CH_W-1:0]     res_ch_r;
    logic [RES_W-1:0]    res_data_r;
    logic                busy_r;
    logic                scan_done_irq_r;
    logic                err_timeout_r;

    logic [CH_W:0]       first_latched_s;
    logic [CH_W:0]       first_cfg_s;
    logic [CH_W:0]       next_latched_s;
    logic                period_done_s;
    logic                settle_done_s;
    logic                timeout_s;

    // Lowest set mask bit at or above 'start'. MSB of the result = found.
    function automatic logic [CH_W:0] find_set_bit(input logic [NUM_CH-1:0] mask,
                                                   input int start);
        logic [CH_W:0] hit;
        hit = {1'b0, {CH_W{1'b0}}};
        for (int i = 0; i < NUM_CH; i++) begin
            if ((hit[CH_W] == 1'b0) && (mask[i] == 1'b1) && (i >= start)) begin
                hit = {1'b1, CH_W'(i)};
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Channel search results and counter terminal-count decodes
    always_comb begin
        first_latched_s = find_set_bit(mask_r, 32'sd0);
        first_cfg_s     = find_set_bit(cfg_ch_mask, 32'sd0);
        next_latched_s  = find_set_bit(mask_r, int'(amux_sel_r) + 32'sd1);
        // A period of 0 behaves like 1: restart on the cycle after entry.
        period_done_s   = (({1'b0, tmr_r} + {{TMR_W{1'b0}}, 1'b1}) >= {1'b0, cfg_period});
        settle_done_s   = (cnt_r == SETTLE_LAST);
        timeout_s       = (cnt_r == TIMEOUT_LAST);
    end

    // Scan state machine with all outputs registered
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_r         <= ST_IDLE;
            mask_r          <= {NUM_CH{1'b0}};
            cnt_r           <= {CNT_W{1'b0}};
            tmr_r           <= {TMR_W{1'b0}};
            pll_en_r        <= 1'b0;
            amux_sel_r      <= {CH_W{1'b0}};
            adc_trigger_r   <= 1'b0;
            res_valid_r     <= 1'b0;
            res_ch_r        <= {CH_W{1'b0}};
            res_data_r      <= {RES_W{1'b0}};
            busy_r          <= 1'b0;
            scan_done_irq_r <= 1'b0;
            err_timeout_r   <= 1'b0;
        end else begin
            adc_trigger_r   <= 1'b0;
            res_valid_r     <= 1'b0;
            scan_done_irq_r <= 1'b0;

            // A timeout set later in this block overrides the clear.
            if (cfg_err_clr) begin
                err_timeout_r <= 1'b0;
            end else begin
                err_timeout_r <= err_timeout_r;
            end

            if ((state_r != ST_IDLE) && !cfg_enable) begin
                // Abort: any result or irq pending this cycle is dropped.
                state_r  <= ST_IDLE;
                pll_en_r <= 1'b0;
                busy_r   <= 1'b0;
                cnt_r    <= {CNT_W{1'b0}};
                tmr_r    <= {TMR_W{1'b0}};
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cfg_start && cfg_enable && (|cfg_ch_mask)) begin
                            mask_r   <= cfg_ch_mask;
                            state_r  <= ST_PLL_WAIT;
                            pll_en_r <= 1'b1;
                            busy_r   <= 1'b1;
                            cnt_r    <= {CNT_W{1'b0}};
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end

                    ST_PLL_WAIT: begin
                        if (pll_locked) begin
                            amux_sel_r <= first_latched_s[CH_W-1:0];
                            state_r    <= ST_SETTLE;
                            cnt_r      <= {CNT_W{1'b0}};
                        end else if (timeout_s) begin
                            err_timeout_r <= 1'b1;
                            pll_en_r      <= 1'b0;
                            busy_r        <= 1'b0;
                            state_r       <= ST_IDLE;
                            cnt_r         <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end

                    ST_SETTLE: begin
                        if (settle_done_s) begin
                            state_r       <= ST_TRIG;
                            adc_trigger_r <= 1'b1;
                            cnt_r         <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end

                    ST_TRIG: begin
                        state_r <= ST_CONVERT;
                        cnt_r   <= {CNT_W{1'b0}};
                    end

                    ST_CONVERT: begin
                        // Done takes priority over a timeout expiring in the same cycle.
                        if (adc_done || timeout_s) begin
                            if (adc_done) begin
                                res_valid_r <= 1'b1;
                                res_ch_r    <= amux_sel_r;
                                res_data_r  <= adc_data;
                            end else begin
                                err_timeout_r <= 1'b1;
                            end
                            cnt_r <= {CNT_W{1'b0}};
                            if (next_latched_s[CH_W]) begin
                                amux_sel_r <= next_latched_s[CH_W-1:0];
                                state_r    <= ST_SETTLE;
                            end else begin
                                scan_done_irq_r <= 1'b1;
                                if (cfg_single) begin
                                    state_r  <= ST_IDLE;
                                    pll_en_r <= 1'b0;
                                    busy_r   <= 1'b0;
                                end else begin
                                    state_r <= ST_PERIOD;
                                    tmr_r   <= {TMR_W{1'b0}};
                                end
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end

                    ST_PERIOD: begin
                        if (period_done_s) begin
                            mask_r <= cfg_ch_mask;
                            tmr_r  <= {TMR_W{1'b0}};
                            if (first_cfg_s[CH_W]) begin
                                amux_sel_r <= first_cfg_s[CH_W-1:0];
                                state_r    <= ST_SETTLE;
                                cnt_r      <= {CNT_W{1'b0}};
                            end else begin
                                state_r  <= ST_IDLE;
                                pll_en_r <= 1'b0;
                                busy_r   <= 1'b0;
                            end
                        end else begin
                            tmr_r <= tmr_r + TMR_ONE;
                        end
                    end

                    default: begin
                        state_r  <= ST_IDLE;
                        pll_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                        cnt_r    <= {CNT_W{1'b0}};
                        tmr_r    <= {TMR_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign pll_en        = pll_en_r;
    assign amux_sel      = amux_sel_r;
    assign adc_trigger   = adc_trigger_r;
    assign res_valid     = res_valid_r;
    assign res_ch        = res_ch_r;
    assign res_data      = res_data_r;
    assign busy          = busy_r;
    assign scan_done_irq = scan_done_irq_r;
    assign err_timeout   = err_timeout_r;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for adc_scan_sequencer. A bench-side ADC model answers
// each trigger after a configurable latency; a monitor logs trigger, result
// and irq events with their cycle numbers. Expected event logs are built from
// the scan timing rules with plain arithmetic and compared entry by entry.
// -----------------------------------------------------------------------------
module tb_adc_scan_sequencer;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 1024;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cfg_enable, cfg_single, cfg_start, cfg_err_clr;
    logic [7:0]  cfg_ch_mask;
    logic [15:0] cfg_period;
    logic        pll_en, pll_locked;
    logic [2:0]  amux_sel;
    logic        adc_trigger, adc_done;
    logic [11:0] adc_data;
    logic        res_valid;
    logic [2:0]  res_ch;
    logic [11:0] res_data;
    logic        busy, scan_done_irq, err_timeout;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    logic [63:0] ev_q[$];
    logic [63:0] exp_q[$];
    logic [11:0] ch_data [8];
    logic [7:0]  dead;
    int          lat;
    bit          pend;
    int          due;
    logic [11:0] pend_data;
    bit          manual_done;

    adc_scan_sequencer #(
        .NUM_CH(8), .CH_W(3), .RES_W(12), .TMR_W(16),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cfg_enable(cfg_enable), .cfg_single(cfg_single), .cfg_start(cfg_start),
        .cfg_ch_mask(cfg_ch_mask), .cfg_period(cfg_period), .cfg_err_clr(cfg_err_clr),
        .pll_en(pll_en), .pll_locked(pll_locked), .amux_sel(amux_sel),
        .adc_trigger(adc_trigger), .adc_done(adc_done), .adc_data(adc_data),
        .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
        .busy(busy), .scan_done_irq(scan_done_irq), .err_timeout(err_timeout)
    );

    always #5 PCLK = ~PCLK;

    // Cycle n is the interval after the n-th rising edge.
    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic logic [63:0] mk_ev(input int kind, input int c, input int ch, input int data);
        return {8'(kind), 24'(c), 8'(ch), 24'(data)};
    endfunction

    // Advance to the middle of the next cycle: log outputs, drive the ADC model.
    task automatic tick();
        @(negedge PCLK);
        if (adc_trigger === 1'b1) begin
            ev_q.push_back(mk_ev(1, cyc, int'(amux_sel), 0));
            if (!dead[amux_sel]) begin
                pend      = 1'b1;
                due       = cyc + lat;
                pend_data = ch_data[amux_sel];
            end
        end
        if (res_valid === 1'b1) ev_q.push_back(mk_ev(2, cyc, int'(res_ch), int'(res_data)));
        if (scan_done_irq === 1'b1) ev_q.push_back(mk_ev(3, cyc, 0, 0));
        if (pend && (cyc == due)) begin
            adc_done = 1'b1;
            adc_data = pend_data;
            pend     = 1'b0;
        end else begin
            adc_done = manual_done;
            adc_data = 12'($urandom);
        end
    endtask

    task automatic pulse_start(input logic [7:0] mask, output int c0);
        cfg_ch_mask = mask;
        cfg_start   = 1'b1;
        c0          = cyc;
        tick();
        cfg_start   = 1'b0;
    endtask

    // Expected events of one scan whose first SETTLE cycle is settle0.
    task automatic model_scan(input int settle0, input logic [7:0] mask, input int l,
                              input logic [7:0] dd, output int t_end);
        int t;
        int trig;
        t = settle0;
        for (int ch = 0; ch < 8; ch++) begin
            if (mask[ch]) begin
                trig = t + SETTLE;
                exp_q.push_back(mk_ev(1, trig, ch, 0));
                if (dd[ch]) begin
                    t = trig + TIMEOUT + 1;
                end else begin
                    t = trig + l + 1;
                    exp_q.push_back(mk_ev(2, t, ch, int'(ch_data[ch])));
                end
            end
        end
        exp_q.push_back(mk_ev(3, t, 0, 0));
        t_end = t;
    endtask

    task automatic test_reset();
        logic [23:0] obs;
        PRESETn = 1'b0;
        repeat (3) tick();
        obs = {pll_en, amux_sel, adc_trigger, res_valid, res_ch, res_data, busy, scan_done_irq, err_timeout};
        vectors++;
        if (obs !== 24'd0) begin miscompares++; $display("FAIL reset_outputs: got %h want 000000", obs); end
        PRESETn = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_busy: got %b want 0", busy); end
        ev_q.delete();
    endtask

    task automatic test_single_spec();
        int c0, t;
        logic [63:0] act;
        ev_q.delete(); exp_q.delete();
        ch_data[0] = 12'h0A5; ch_data[2] = 12'h3C1; lat = 3;
        pulse_start(8'b0000_0101, c0);
        vectors++;
        if ({busy, pll_en} !== 2'b11) begin miscompares++; $display("FAIL spec_pll_wait: got %b want 11", {busy, pll_en}); end
        tick();
        vectors++;
        if (amux_sel !== 3'd0) begin miscompares++; $display("FAIL spec_amux_first: got %0d want 0", amux_sel); end
        model_scan(c0 + 2, 8'b0000_0101, 3, 8'h00, t);
        while (cyc < t + 3) tick();
        vectors++;
        if ({busy, pll_en} !== 2'b00) begin miscompares++; $display("FAIL spec_idle: got %b want 00", {busy, pll_en}); end
        vectors++;
        if (ev_q.size() != exp_q.size()) begin miscompares++; $display("FAIL spec_log_len: got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            act = (i < ev_q.size()) ? ev_q[i] : 64'd0;
            vectors++;
            if (act !== exp_q[i]) begin miscompares++; $display("FAIL spec_ev%0d: got %h want %h", i, act, exp_q[i]); end
        end
    endtask

    task automatic test_single_random();
        int c0, t;
        logic [7:0] mask;
        logic [63:0] act;
        repeat (4) begin
            ev_q.delete(); exp_q.delete();
            foreach (ch_data[i]) ch_data[i] = 12'($urandom);
            mask = 8'($urandom_range(1, 255));
            lat  = $urandom_range(1, 6);
            pulse_start(mask, c0);
            tick();
            // Start while busy plus a new mask: both must be ignored.
            cfg_ch_mask = 8'($urandom);
            cfg_start   = 1'b1;
            tick();
            cfg_start   = 1'b0;
            model_scan(c0 + 2, mask, lat, 8'h00, t);
            while (cyc < t + 3) tick();
            vectors++;
            if ({busy, pll_en} !== 2'b00) begin miscompares++; $display("FAIL rand_idle: got %b want 00", {busy, pll_en}); end
            vectors++;
            if (ev_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_log_len mask %h: got %0d want %0d", mask, ev_q.size(), exp_q.size()); end
            foreach (exp_q[i]) begin
                act = (i < ev_q.size()) ? ev_q[i] : 64'd0;
                vectors++;
                if (act !== exp_q[i]) begin miscompares++; $display("FAIL rand_ev%0d mask %h: got %h want %h", i, mask, act, exp_q[i]); end
            end
        end
        lat = 3;
    endtask

    task automatic test_ignored();
        int c0, bad;
        ev_q.delete();
        pulse_start(8'h00, c0);
        bad = (busy !== 1'b0) ? 1 : 0;
        repeat (3) begin tick(); if (busy !== 1'b0) bad++; end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL start_mask0: got %0d busy cycles want 0", bad); end
        cfg_enable = 1'b0;
        pulse_start(8'h0F, c0);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL start_disabled: got busy %b want 0", busy); end
        cfg_enable  = 1'b1;
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        repeat (3) tick();
        vectors++;
        if (ev_q.size() != 0) begin miscompares++; $display("FAIL idle_done: got %0d events want 0", ev_q.size()); end
    endtask

    task automatic test_continuous();
        int c0, t, s, low;
        logic [63:0] act;
        ev_q.delete(); exp_q.delete();
        cfg_single = 1'b0; cfg_period = 16'd10; lat = 2;
        ch_data[7] = 12'($urandom);
        pulse_start(8'h80, c0);
        s = c0 + 2;
        for (int k = 0; k < 3; k++) begin
            model_scan(s, 8'h80, 2, 8'h00, t);
            s = t + 10;
        end
        low = 0;
        while (cyc < s + 1) begin tick(); if (pll_en !== 1'b1) low++; end
        vectors++;
        if (low != 0) begin miscompares++; $display("FAIL cont_pll_held: got %0d low cycles want 0", low); end
        cfg_enable = 1'b0;
        tick();
        vectors++;
        if ({busy, pll_en} !== 2'b00) begin miscompares++; $display("FAIL cont_abort: got %b want 00", {busy, pll_en}); end
        repeat (10) tick();
        vectors++;
        if (ev_q.size() != exp_q.size()) begin miscompares++; $display("FAIL cont_log_len: got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            act = (i < ev_q.size()) ? ev_q[i] : 64'd0;
            vectors++;
            if (act !== exp_q[i]) begin miscompares++; $display("FAIL cont_ev%0d: got %h want %h", i, act, exp_q[i]); end
        end
        cfg_enable = 1'b1; cfg_single = 1'b1;
    endtask

    task automatic test_continuous_random();
        int c0, t1, t2, s2, p, m;
        logic [7:0] mask;
        logic [63:0] act;
        ev_q.delete(); exp_q.delete();
        foreach (ch_data[i]) ch_data[i] = 12'($urandom);
        mask = 8'($urandom_range(1, 255));
        p    = $urandom_range(0, 4);
        m    = (p == 0) ? 1 : p;
        lat  = $urandom_range(1, 5);
        cfg_single = 1'b0; cfg_period = 16'(p);
        pulse_start(mask, c0);
        model_scan(c0 + 2, mask, lat, 8'h00, t1);
        s2 = t1 + m;
        model_scan(s2, mask, lat, 8'h00, t2);
        while (cyc < s2) tick();
        cfg_ch_mask = 8'h00;
        while (cyc < t2 + m - 1) tick();
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL crand_period_busy p=%0d: got %b want 1", p, busy); end
        tick();
        vectors++;
        if ({busy, pll_en} !== 2'b00) begin miscompares++; $display("FAIL crand_mask0_idle p=%0d: got %b want 00", p, {busy, pll_en}); end
        repeat (8) tick();
        vectors++;
        if (ev_q.size() != exp_q.size()) begin miscompares++; $display("FAIL crand_log_len: got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            act = (i < ev_q.size()) ? ev_q[i] : 64'd0;
            vectors++;
            if (act !== exp_q[i]) begin miscompares++; $display("FAIL crand_ev%0d p=%0d: got %h want %h", i, p, act, exp_q[i]); end
        end
        cfg_single = 1'b1; lat = 3;
    endtask

    task automatic test_pll_timeout();
        int c0;
        ev_q.delete();
        pll_locked = 1'b0;
        pulse_start(8'h01, c0);
        while (cyc < c0 + TIMEOUT) tick();
        vectors++;
        if ({err_timeout, busy} !== 2'b01) begin miscompares++; $display("FAIL pll_before_expiry: got %b want 01", {err_timeout, busy}); end
        tick();
        vectors++;
        if ({err_timeout, busy, pll_en} !== 3'b100) begin miscompares++; $display("FAIL pll_expiry: got %b want 100", {err_timeout, busy, pll_en}); end
        cfg_err_clr = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
        vectors++;
        if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b want 0", err_timeout); end
        // Clear held across the expiry cycle: the set must win.
        pulse_start(8'h02, c0);
        while (cyc < c0 + TIMEOUT) tick();
        cfg_err_clr = 1'b1;
        tick();
        vectors++;
        if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL err_set_wins: got %b want 1", err_timeout); end
        tick();
        vectors++;
        if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL err_clear_after: got %b want 0", err_timeout); end
        cfg_err_clr = 1'b0;
        vectors++;
        if (ev_q.size() != 0) begin miscompares++; $display("FAIL pll_no_events: got %0d want 0", ev_q.size()); end
        pll_locked = 1'b1;
    endtask

    task automatic test_dead_channel();
        int c0, t;
        logic [63:0] act;
        ev_q.delete(); exp_q.delete();
        ch_data[1] = 12'($urandom);
        dead = 8'h01; lat = 2;
        pulse_start(8'h03, c0);
        model_scan(c0 + 2, 8'h03, 2, 8'h01, t);
        while (cyc < c0 + 2 + SETTLE + TIMEOUT) tick();
        vectors++;
        if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL dead_before_expiry: got %b want 0", err_timeout); end
        tick();
        vectors++;
        if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL dead_expiry: got %b want 1", err_timeout); end
        while (cyc < t + 3) tick();
        vectors++;
        if ({err_timeout, busy} !== 2'b10) begin miscompares++; $display("FAIL dead_end: got %b want 10", {err_timeout, busy}); end
        vectors++;
        if (ev_q.size() != exp_q.size()) begin miscompares++; $display("FAIL dead_log_len: got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            act = (i < ev_q.size()) ? ev_q[i] : 64'd0;
            vectors++;
            if (act !== exp_q[i]) begin miscompares++; $display("FAIL dead_ev%0d: got %h want %h", i, act, exp_q[i]); end
        end
        dead = 8'h00;
        cfg_err_clr = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
        lat = 3;
    endtask

    task automatic test_done_at_expiry();
        int c0, t;
        logic [63:0] act;
        ev_q.delete(); exp_q.delete();
        ch_data[6] = 12'($urandom);
        lat = TIMEOUT;
        pulse_start(8'h40, c0);
        model_scan(c0 + 2, 8'h40, TIMEOUT, 8'h00, t);
        while (cyc < t + 3) tick();
        vectors++;
        if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL expiry_done_err: got %b want 0", err_timeout); end
        vectors++;
        if (ev_q.size() != exp_q.size()) begin miscompares++; $display("FAIL expiry_log_len: got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            act = (i < ev_q.size()) ? ev_q[i] : 64'd0;
            vectors++;
            if (act !== exp_q[i]) begin miscompares++; $display("FAIL expiry_ev%0d: got %h want %h", i, act, exp_q[i]); end
        end
        lat = 3;
    endtask

    task automatic test_reset_mid_convert();
        int c0;
        logic [23:0] obs;
        logic [63:0] act;
        ev_q.delete(); exp_q.delete();
        lat = 10;
        pulse_start(8'h10, c0);
        exp_q.push_back(mk_ev(1, c0 + 2 + SETTLE, 4, 0));
        while (cyc < c0 + 2 + SETTLE + 3) tick();
        PRESETn = 1'b0;
        tick();
        obs = {pll_en, amux_sel, adc_trigger, res_valid, res_ch, res_data, busy, scan_done_irq, err_timeout};
        vectors++;
        if (obs !== 24'd0) begin miscompares++; $display("FAIL midreset_outputs: got %h want 000000", obs); end
        PRESETn = 1'b1;
        repeat (15) tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy); end
        vectors++;
        if (ev_q.size() != exp_q.size()) begin miscompares++; $display("FAIL midreset_log_len: got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            act = (i < ev_q.size()) ? ev_q[i] : 64'd0;
            vectors++;
            if (act !== exp_q[i]) begin miscompares++; $display("FAIL midreset_ev%0d: got %h want %h", i, act, exp_q[i]); end
        end
        lat = 3;
    endtask

    initial begin
        PRESETn     = 1'b0;
        cfg_enable  = 1'b1;
        cfg_single  = 1'b1;
        cfg_start   = 1'b0;
        cfg_ch_mask = 8'h00;
        cfg_period  = 16'd0;
        cfg_err_clr = 1'b0;
        pll_locked  = 1'b1;
        adc_done    = 1'b0;
        adc_data    = 12'h000;
        dead        = 8'h00;
        lat         = 3;
        pend        = 1'b0;
        due         = 0;
        pend_data   = 12'h000;
        manual_done = 1'b0;
        foreach (ch_data[i]) ch_data[i] = 12'h000;

        test_reset();
        test_single_spec();
        test_single_random();
        test_ignored();
        test_continuous();
        test_continuous_random();
        test_pll_timeout();
        test_dead_channel();
        test_done_at_expiry();
        test_reset_mid_convert();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
